mem_ext_arbiter: RTL and testbench

MEM_EXT_ARBITER -- requirements
Module: mem_ext_arbiter

---
 rtl/mem_ext_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_ext_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ext_arbiter.sv
// Two-requester external memory arbiter: grants an instruction or data tile owner
// and runs a 16-word burst on the external bus with stall handling and timeout abort.
module mem_ext_arbiter #(
    parameter int TMO_LIM = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iReq,
    input  logic [41:0] iAddr,
    input  logic        dReq,
    input  logic        dWr,
    input  logic [41:0] dAddr,
    output logic        iGnt,
    output logic        dGnt,
    output logic        iDone,
    output logic        dDone,
    output logic        busErr,
    output logic [3:0]  wIdx,
    input  logic [31:0] dWrData,
    output logic        rdValid,
    output logic [3:0]  rdIdx,
    output logic [31:0] rdData,
    output logic [47:0] extAddr,
    output logic [31:0] extDataOut,
    input  logic [31:0] extDataIn,
    output logic        extOE,
    output logic        extWR,
    input  logic        extNotReady,
    output logic        extHold
);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      state;
    logic        ownerD;
    logic        lastGntD;
    logic [7:0]  tmoCnt;
    logic [7:0]  tmoNext;
    logic        tmoHit;
    logic        pickD;

    // On a tie the requester that did not own the previous burst wins.
    assign pickD   = dReq & (~iReq | ~lastGntD);
    assign tmoNext = satInc(tmoCnt);
    assign tmoHit  = (int'(tmoNext) >= TMO_LIM);

    assign extDataOut = extWR ? dWrData : 32'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ownerD   <= 1'b0;
            lastGntD <= 1'b0;
            tmoCnt   <= 8'd0;
            iGnt     <= 1'b0;
            dGnt     <= 1'b0;
            iDone    <= 1'b0;
            dDone    <= 1'b0;
            busErr   <= 1'b0;
            wIdx     <= 4'd0;
            rdValid  <= 1'b0;
            rdIdx    <= 4'd0;
            rdData   <= 32'd0;
            extAddr  <= 48'd0;
            extOE    <= 1'b0;
            extWR    <= 1'b0;
            extHold  <= 1'b0;
        end else begin
            rdValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (iReq || dReq) begin
                        ownerD  <= pickD;
                        iGnt    <= ~pickD;
                        dGnt    <= pickD;
                        extHold <= 1'b1;
                        extAddr <= {(pickD ? dAddr : iAddr), 6'd0};
                        extOE   <= ~(pickD & dWr);
                        extWR   <= pickD & dWr;
                        wIdx    <= 4'd0;
                        tmoCnt  <= 8'd0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    tmoCnt <= 8'd0;
                    state  <= XFER;
                end
                XFER: begin
                    if (!extNotReady) begin
                        tmoCnt       <= 8'd0;
                        wIdx         <= wIdx + 4'd1;
                        extAddr[5:2] <= wIdx + 4'd1;
                        if (!extWR) begin
                            rdValid <= 1'b1;
                            rdIdx   <= wIdx;
                            rdData  <= extDataIn;
                        end
                        if (wIdx == 4'd15) begin
                            extOE <= 1'b0;
                            extWR <= 1'b0;
                            iDone <= ~ownerD;
                            dDone <= ownerD;
                            state <= DONE;
                        end
                    end else begin
                        // Stalled word: address and index hold until the bus answers or times out.
                        tmoCnt <= tmoNext;
                        if (tmoHit) begin
                            extOE  <= 1'b0;
                            extWR  <= 1'b0;
                            iDone  <= ~ownerD;
                            dDone  <= ownerD;
                            busErr <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    iDone    <= 1'b0;
                    dDone    <= 1'b0;
                    busErr   <= 1'b0;
                    iGnt     <= 1'b0;
                    dGnt     <= 1'b0;
                    extHold  <= 1'b0;
                    extAddr  <= 48'd0;
                    wIdx     <= 4'd0;
                    tmoCnt   <= 8'd0;
                    lastGntD <= ownerD;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ext_arbiter.sv
// Bench for mem_ext_arbiter: directed and randomized bursts checked cycle by cycle
// against a burst-level reference model of the arbitration and transfer rules.
module tb_mem_ext_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        iReq, dReq, dWr, extNotReady;
    logic [41:0] iAddr, dAddr;
    logic [31:0] dWrData, extDataIn, wrPat;

    logic        iGnt, dGnt, iDone, dDone, busErr, rdValid, extOE, extWR, extHold;
    logic [3:0]  wIdx, rdIdx;
    logic [31:0] rdData, extDataOut;
    logic [47:0] extAddr;

    logic        tIGnt, tDGnt, tIDone, tDDone, tBusErr, tRdValid, tExtOE, tExtWR, tExtHold;
    logic [3:0]  tWIdx, tRdIdx;
    logic [31:0] tRdData, tExtDataOut;
    logic [47:0] tExtAddr;

    int nErr = 0;
    int nChk = 0;
    bit lastD;

    always #5 clock = ~clock;

    // Tile array model: writeback word is the burst pattern tagged with the word index.
    assign dWrData = wrPat | {28'd0, wIdx};

    mem_ext_arbiter dut (
        .clock(clock), .reset(reset), .iReq(iReq), .iAddr(iAddr), .dReq(dReq), .dWr(dWr),
        .dAddr(dAddr), .iGnt(iGnt), .dGnt(dGnt), .iDone(iDone), .dDone(dDone), .busErr(busErr),
        .wIdx(wIdx), .dWrData(dWrData), .rdValid(rdValid), .rdIdx(rdIdx), .rdData(rdData),
        .extAddr(extAddr), .extDataOut(extDataOut), .extDataIn(extDataIn), .extOE(extOE),
        .extWR(extWR), .extNotReady(extNotReady), .extHold(extHold)
    );

    mem_ext_arbiter #(.TMO_LIM(4)) dutT (
        .clock(clock), .reset(reset), .iReq(iReq), .iAddr(iAddr), .dReq(dReq), .dWr(dWr),
        .dAddr(dAddr), .iGnt(tIGnt), .dGnt(tDGnt), .iDone(tIDone), .dDone(tDDone), .busErr(tBusErr),
        .wIdx(tWIdx), .dWrData(dWrData), .rdValid(tRdValid), .rdIdx(tRdIdx), .rdData(tRdData),
        .extAddr(tExtAddr), .extDataOut(tExtDataOut), .extDataIn(extDataIn), .extOE(tExtOE),
        .extWR(tExtWR), .extNotReady(extNotReady), .extHold(tExtHold)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChk++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string ph, input bit gI, input bit gD, input bit oe, input bit wr,
                       input logic [3:0] wi, input bit ckA, input logic [47:0] addr,
                       input logic [31:0] dout, input bit rv, input logic [3:0] ri,
                       input logic [31:0] rd, input bit dI, input bit dD);
        chk({ph, ".iGnt"}, iGnt, gI);
        chk({ph, ".dGnt"}, dGnt, gD);
        chk({ph, ".extHold"}, extHold, 1'b1);
        chk({ph, ".extOE"}, extOE, oe);
        chk({ph, ".extWR"}, extWR, wr);
        chk({ph, ".wIdx"}, wIdx, wi);
        if (ckA) chk({ph, ".extAddr"}, extAddr, addr);
        chk({ph, ".extDataOut"}, extDataOut, dout);
        chk({ph, ".rdValid"}, rdValid, rv);
        if (rv) begin
            chk({ph, ".rdIdx"}, rdIdx, ri);
            chk({ph, ".rdData"}, rdData, rd);
        end
        chk({ph, ".iDone"}, iDone, dI);
        chk({ph, ".dDone"}, dDone, dD);
        chk({ph, ".busErr"}, busErr, 1'b0);
    endtask

    // Entered and left at posedge+1; the IDLE cycle before the grant is checked here.
    task automatic burst(input string nm, input bit rI, input bit rD, input bit wrReq,
                         input logic [41:0] aI, input logic [41:0] aD, input logic [31:0] rdBase,
                         input logic [31:0] pat, input int stallW, input int stallN);
        bit own, wr, pendV;
        logic [41:0] base;
        logic [3:0]  pendI;
        logic [31:0] pendD;
        int          nSt;
        own  = rD && (!rI || !lastD);
        wr   = own && wrReq;
        base = own ? aD : aI;
        iReq = rI; dReq = rD; dWr = wrReq; iAddr = aI; dAddr = aD; wrPat = pat;
        extNotReady = 1'b0;
        @(negedge clock);
        chk({nm, ".idle.iGnt"}, iGnt, 1'b0);
        chk({nm, ".idle.dGnt"}, dGnt, 1'b0);
        chk({nm, ".idle.extHold"}, extHold, 1'b0);
        chk({nm, ".idle.extOE"}, extOE, 1'b0);
        @(posedge clock); #1;
        if (own) dReq = 1'b0; else iReq = 1'b0;
        dWr = ~dWr; iAddr = ~aI; dAddr = ~aD;
        extNotReady = 1'($urandom);
        extDataIn = $urandom;
        @(negedge clock);
        cyc({nm, ".setup"}, !own, own, !wr, wr, 4'd0, 1'b1, {base, 6'd0}, wr ? pat : 32'd0,
            1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clock); #1;
        pendV = 1'b0; pendI = 4'd0; pendD = 32'd0;
        for (int w = 0; w < 16; w++) begin
            nSt = (w == stallW) ? stallN : 0;
            for (int s = 0; s < nSt; s++) begin
                extNotReady = 1'b1;
                extDataIn = $urandom;
                @(negedge clock);
                cyc({nm, ".stall"}, !own, own, !wr, wr, 4'(w), 1'b1, {base, 4'(w), 2'b00},
                    wr ? (pat | 32'(w)) : 32'd0, pendV, pendI, pendD, 1'b0, 1'b0);
                pendV = 1'b0;
                @(posedge clock); #1;
            end
            extNotReady = 1'b0;
            extDataIn = rdBase + 32'(w);
            @(negedge clock);
            cyc({nm, ".xfer"}, !own, own, !wr, wr, 4'(w), 1'b1, {base, 4'(w), 2'b00},
                wr ? (pat | 32'(w)) : 32'd0, pendV, pendI, pendD, 1'b0, 1'b0);
            pendV = !wr; pendI = 4'(w); pendD = rdBase + 32'(w);
            @(posedge clock); #1;
        end
        @(negedge clock);
        cyc({nm, ".done"}, !own, own, 1'b0, 1'b0, 4'd0, 1'b0, 48'd0, 32'd0,
            pendV, pendI, pendD, !own, own);
        lastD = own;
        @(posedge clock); #1;
    endtask

    task automatic rstPulse();
        iReq = 1'b0; dReq = 1'b0; extNotReady = 1'b0;
        reset = 1'b0;
        lastD = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=still-running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rI, rD, found;
        int rdCnt, stalls;
        reset = 1'b0; iReq = 1'b0; dReq = 1'b0; dWr = 1'b0; iAddr = '0; dAddr = '0;
        extNotReady = 1'b0; extDataIn = '0; wrPat = '0; lastD = 1'b0;
        #12;
        chk("rst.iGnt", iGnt, 1'b0);
        chk("rst.dGnt", dGnt, 1'b0);
        chk("rst.extHold", extHold, 1'b0);
        chk("rst.extAddr", extAddr, 48'd0);
        chk("rst.extDataOut", extDataOut, 32'd0);
        chk("rst.extOE", extOE, 1'b0);
        chk("rst.wIdx", wIdx, 4'd0);
        chk("rst.rdValid", rdValid, 1'b0);
        chk("rst.rdData", rdData, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;

        burst("fillI", 1'b1, 1'b0, 1'b0, 42'h040, 42'h3, 32'h1000, 32'd0, 0, 0);

        rstPulse();
        burst("tie1", 1'b1, 1'b1, 1'b0, 42'h123, 42'h456, 32'h2000, 32'd0, 0, 0);
        burst("pendI", 1'b1, 1'b0, 1'b0, 42'h123, 42'h456, 32'h3000, 32'd0, 0, 0);
        burst("tie2", 1'b1, 1'b1, 1'b1, 42'h777, 42'h888, 32'h4000, 32'h5A000000, 0, 0);

        burst("wbStall", 1'b0, 1'b1, 1'b1, 42'h11, 42'h2ABCD, 32'h0, 32'hA5000000, 5, 3);

        for (int k = 0; k < 8; k++) begin
            rI = 1'($urandom);
            rD = rI ? 1'($urandom) : 1'b1;
            burst($sformatf("rnd%0d", k), rI, rD, 1'($urandom),
                  {10'($urandom), $urandom}, {10'($urandom), $urandom}, $urandom,
                  $urandom & 32'hFFFF_FFF0, int'($urandom_range(15, 0)), int'($urandom_range(3, 0)));
        end

        rstPulse();
        iReq = 1'b1; iAddr = 42'h99; extNotReady = 1'b0;
        @(posedge clock); #1;
        iReq = 1'b0;
        rdCnt = 0;
        repeat (3) begin
            extDataIn = $urandom;
            @(negedge clock);
            rdCnt += int'(tRdValid);
            @(posedge clock); #1;
        end
        extNotReady = 1'b1;
        stalls = 0; found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clock);
            rdCnt += int'(tRdValid);
            if (tIDone) begin
                found = 1'b1;
                chk("tmo.busErr", tBusErr, 1'b1);
            end else begin
                stalls++;
            end
            @(posedge clock); #1;
        end
        chk("tmo.doneSeen", found, 1'b1);
        chk("tmo.stallCycles", stalls, 4);
        repeat (3) begin
            @(negedge clock);
            rdCnt += int'(tRdValid);
            @(posedge clock); #1;
        end
        chk("tmo.rdValidCount", rdCnt, 2);
        chk("tmo.extOE", tExtOE, 1'b0);
        chk("tmo.iDone", tIDone, 1'b0);

        rstPulse();
        dReq = 1'b1; dWr = 1'b1; dAddr = 42'h1F00; wrPat = 32'hA5000000;
        @(posedge clock); #1;
        dReq = 1'b0; iReq = 1'b1; iAddr = 42'h2222;
        repeat (8) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rstMid.wIdx", wIdx, 4'd7);
        chk("rstMid.extWR", extWR, 1'b1);
        #1 reset = 1'b0;
        lastD = 1'b0;
        #1;
        chk("rstMid.zero.wIdx", wIdx, 4'd0);
        chk("rstMid.zero.extAddr", extAddr, 48'd0);
        chk("rstMid.zero.extDataOut", extDataOut, 32'd0);
        chk("rstMid.zero.extWR", extWR, 1'b0);
        chk("rstMid.zero.extHold", extHold, 1'b0);
        chk("rstMid.zero.dGnt", dGnt, 1'b0);
        @(posedge clock); #1;
        chk("rstMid.noDone", dDone, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rstMid.iGnt", iGnt, 1'b1);
        chk("rstMid.dGnt2", dGnt, 1'b0);
        chk("rstMid.extAddr2", extAddr, {42'h2222, 6'd0});

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end

endmodule
